mem_arbiter: RTL



---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the fetch / load-store memory arbiter.
package mem_arbiter_pkg;

  localparam logic MEM_REQ_READ  = 1'b0;
  localparam logic MEM_REQ_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_e;

  // Two-way round robin: on contention the side that did not win last time goes.
  function automatic grant_e arb_rr2(input logic if_v, input logic d_v, input grant_e last);
    if (d_v && (!if_v || last == GRANT_FETCH)) return GRANT_DATA;
    return GRANT_FETCH;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and load/store.
// Accept in IDLE, present the captured request in REQ, route the response in RESP.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  input  logic [ADDR_W-1:0]     if_req_addr,
  output logic                  if_req_ready,
  output logic                  if_resp_valid,
  output logic [DATA_W-1:0]     if_resp_data,
  input  logic                  d_req_valid,
  input  logic                  d_req_write,
  input  logic [ADDR_W-1:0]     d_req_addr,
  input  logic [DATA_W-1:0]     d_req_wdata,
  input  logic [DATA_W/8-1:0]   d_req_wmask,
  output logic                  d_req_ready,
  output logic                  d_resp_valid,
  output logic [DATA_W-1:0]     d_resp_data,
  output logic                  mem_req_valid,
  output logic                  mem_req_write,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic [DATA_W-1:0]     mem_req_wdata,
  output logic [DATA_W/8-1:0]   mem_req_wmask,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_resp_data,
  output logic                  stray_resp
);

  localparam int MASK_W = DATA_W / 8;

  arb_state_e          state_q;
  grant_e              last_grant_q;
  grant_e              owner_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;
  logic                stray_q;

  grant_e grant;
  logic   idle;
  logic   if_accept;
  logic   d_accept;
  logic   resp_hit;

  // Gating with rst keeps the combinational outputs at 0 during reset.
  assign grant     = arb_rr2(if_req_valid, d_req_valid, last_grant_q);
  assign idle      = (state_q == ARB_IDLE) && !rst;
  assign if_accept = idle && if_req_valid && (grant == GRANT_FETCH);
  assign d_accept  = idle && d_req_valid && (grant == GRANT_DATA);
  assign resp_hit  = (state_q == ARB_RESP) && mem_resp_valid && !rst;

  assign if_req_ready  = if_accept;
  assign d_req_ready   = d_accept;
  assign if_resp_valid = resp_hit && (owner_q == GRANT_FETCH);
  assign d_resp_valid  = resp_hit && (owner_q == GRANT_DATA);
  assign if_resp_data  = if_resp_valid ? mem_resp_data : '0;
  assign d_resp_data   = d_resp_valid ? mem_resp_data : '0;

  assign mem_req_valid = (state_q == ARB_REQ);
  assign mem_req_write = write_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;
  assign stray_resp    = stray_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= GRANT_FETCH;
      owner_q      <= GRANT_FETCH;
      addr_q       <= '0;
      write_q      <= MEM_REQ_READ;
      wdata_q      <= '0;
      wmask_q      <= '0;
      stray_q      <= 1'b0;
    end else begin
      if (mem_resp_valid && state_q != ARB_RESP) stray_q <= 1'b1;
      case (state_q)
        ARB_IDLE: begin
          if (d_accept) begin
            addr_q       <= d_req_addr;
            write_q      <= d_req_write;
            wdata_q      <= d_req_wdata;
            wmask_q      <= d_req_wmask;
            owner_q      <= GRANT_DATA;
            last_grant_q <= GRANT_DATA;
            state_q      <= ARB_REQ;
          end else if (if_accept) begin
            addr_q       <= if_req_addr;
            write_q      <= MEM_REQ_READ;
            wdata_q      <= '0;
            wmask_q      <= '0;
            owner_q      <= GRANT_FETCH;
            last_grant_q <= GRANT_FETCH;
            state_q      <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (mem_req_ready) state_q <= ARB_RESP;
        end
        ARB_RESP: begin
          if (mem_resp_valid) state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule
